// File: rtl/alu_ops_pkg.sv
// Shared opcode constants, FSM states and hold-count width for the ALU
// sharing controller.
package alu_ops_pkg;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_AND = 5'b00001;
  localparam logic [4:0] OP_OR  = 5'b00010;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_XOR = 5'b00101;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-input arbiter with one-hot winner; round-robin pointer only when
// ALU_SHARE_RR_EN is defined, fixed port-0 priority otherwise.
module arb2_rr (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] win
);

`ifdef ALU_SHARE_RR_EN
  // prio1 set means port 1 was not granted most recently
  logic prio1;

  always_ff @(posedge clock) begin
    if (reset) begin
      prio1 <= 1'b0;
    end else if (en) begin
      prio1 <= win[0];
    end
  end

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = prio1 ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clock, reset, en};

  always_comb begin
    win = 2'b00;
    if (req[0]) begin
      win = 2'b01;
    end else if (req[1]) begin
      win = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; optional
// round-robin arbitration under ALU_SHARE_RR_EN.
module alu_share_ctrl
  import alu_ops_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4,
  parameter int SIMPLE_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [4:0]  op0,
  input  logic [4:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] result,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_ra,
  output logic [31:0] alu_rb,
  input  logic [63:0] alu_rc
);

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MULDIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] SP_LOAD = CNT_W'(SIMPLE_CYCLES - 1);

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              owner, owner_d;
  logic [1:0]        gnt_d, done_d;
  logic [63:0]       result_d;
  logic [4:0]        op_d, op_sel;
  logic [31:0]       ra_d, rb_d, a_sel, b_sel;
  logic [1:0]        win;
  logic              arb_en;

  arb2_rr u_arb (
    .clock (clock),
    .reset (reset),
    .req   ({req1, req0}),
    .en    (arb_en),
    .win   (win)
  );

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    owner_d  = owner;
    gnt_d    = 2'b00;
    done_d   = 2'b00;
    result_d = result;
    op_d     = alu_opcode;
    ra_d     = alu_ra;
    rb_d     = alu_rb;
    arb_en   = 1'b0;
    op_sel   = win[1] ? op1 : op0;
    a_sel    = win[1] ? a1 : a0;
    b_sel    = win[1] ? b1 : b0;
    unique case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          arb_en  = 1'b1;
          gnt_d   = win;
          owner_d = win[1];
          op_d    = op_sel;
          ra_d    = a_sel;
          rb_d    = b_sel;
          cnt_d   = is_muldiv(op_sel) ? MD_LOAD : SP_LOAD;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          result_d = alu_rc;
          done_d   = owner ? 2'b10 : 2'b01;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result     <= '0;
      alu_opcode <= '0;
      alu_ra     <= '0;
      alu_rb     <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      owner      <= owner_d;
      gnt0       <= gnt_d[0];
      gnt1       <= gnt_d[1];
      done0      <= done_d[0];
      done1      <= done_d[1];
      result     <= result_d;
      alu_opcode <= op_d;
      alu_ra     <= ra_d;
      alu_rb     <= rb_d;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl: vector table, corner sequences
// and a randomized run against a transaction-level model.
module tb_alu_share_ctrl;
  import alu_ops_pkg::*;

  localparam int MD = 4;
  localparam int SP = 1;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [4:0]  op0, op1;
  logic [31:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, done0, done1;
  logic [63:0] result;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_ra, alu_rb;
  logic [63:0] alu_rc;

  always #5 clock = ~clock;

  alu_share_ctrl #(.MULDIV_CYCLES(MD), .SIMPLE_CYCLES(SP)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .result(result),
    .alu_opcode(alu_opcode),
    .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_rc(alu_rc)
  );

  // ALU stand-in: 32-bit ops zero-extended, full 64-bit product
  function automatic logic [63:0] alu_f(input logic [4:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      5'b00001: return {32'h0, a & b};
      5'b00010: return {32'h0, a | b};
      5'b00011: return {32'h0, a + b};
      5'b00100: return {32'h0, a - b};
      5'b00101: return {32'h0, a ^ b};
      5'b01111: return {32'h0, a} * {32'h0, b};
      5'b10000: return (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'h0, a / b};
      default:  return 64'h0;
    endcase
  endfunction

  always_comb alu_rc = alu_f(alu_opcode, alu_ra, alu_rb);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // transaction-level model: cycle numbers of the pending grant/done
  int k, gnt_cyc, done_cyc, free_cyc, pw, last_w;
  int g0cnt, g1cnt;
  logic [63:0] pres, cur_res;
  logic [4:0]  pop;
  logic [31:0] pa, pb;

  task automatic model_sync();
    k = 0; gnt_cyc = -1; done_cyc = -1; free_cyc = 0;
    cur_res = 64'h0; last_w = 1; pw = 0;
  endtask

  task automatic check_cycle();
    if (k == done_cyc) cur_res = pres;
    chk("gnt0", 64'(gnt0), 64'(k == gnt_cyc && pw == 0));
    chk("gnt1", 64'(gnt1), 64'(k == gnt_cyc && pw == 1));
    chk("done0", 64'(done0), 64'(k == done_cyc && pw == 0));
    chk("done1", 64'(done1), 64'(k == done_cyc && pw == 1));
    chk("result", result, cur_res);
    if (gnt_cyc >= 0 && k >= gnt_cyc && k <= done_cyc) begin
      chk("alu_opcode", 64'(alu_opcode), 64'(pop));
      chk("alu_ra", 64'(alu_ra), 64'(pa));
      chk("alu_rb", 64'(alu_rb), 64'(pb));
    end
    if (gnt0) g0cnt++;
    if (gnt1) g1cnt++;
  endtask

  task automatic drive(input logic r0, input logic [4:0] o0,
                       input logic [31:0] x0, input logic [31:0] y0,
                       input logic r1, input logic [4:0] o1,
                       input logic [31:0] x1, input logic [31:0] y1);
    int w, lat;
    req0 = r0; op0 = o0; a0 = x0; b0 = y0;
    req1 = r1; op1 = o1; a1 = x1; b1 = y1;
    if (k >= free_cyc && (r0 || r1)) begin
`ifdef ALU_SHARE_RR_EN
      if (r0 && r1) w = (last_w == 0) ? 1 : 0;
      else w = r0 ? 0 : 1;
`else
      w = r0 ? 0 : 1;
`endif
      last_w = w;
      pw = w;
      pop = w ? o1 : o0;
      pa = w ? x1 : x0;
      pb = w ? y1 : y0;
      lat = (pop == 5'b01111 || pop == 5'b10000) ? MD : SP;
      pres = alu_f(pop, pa, pb);
      gnt_cyc = k + 1;
      done_cyc = k + lat + 1;
      free_cyc = k + lat + 2;
    end
  endtask

  task automatic model_cycle(input logic r0, input logic [4:0] o0,
                             input logic [31:0] x0, input logic [31:0] y0,
                             input logic r1, input logic [4:0] o1,
                             input logic [31:0] x1, input logic [31:0] y1);
    @(negedge clock);
    k++;
    check_cycle();
    drive(r0, o0, x0, y0, r1, o1, x1, y1);
  endtask

  function automatic logic [4:0] rand_op();
    case ($urandom_range(0, 7))
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_AND;
      3: return OP_OR;
      4: return OP_XOR;
      5: return OP_MUL;
      6: return OP_DIV;
      default: return 5'($urandom_range(17, 31));
    endcase
  endfunction

  task automatic idle_cycle();
    model_cycle(1'b0, rand_op(), $urandom, $urandom,
                1'b0, rand_op(), $urandom, $urandom);
  endtask

  task automatic reset_hold(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      chk("rst_gnt", 64'({gnt1, gnt0}), 64'h0);
      chk("rst_done", 64'({done1, done0}), 64'h0);
      chk("rst_result", result, 64'h0);
      chk("rst_alu_in", {alu_ra, alu_rb} ^ 64'(alu_opcode), 64'h0);
    end
    reset = 1'b0;
    model_sync();
  endtask

  typedef struct {
    bit          port;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int lat;
    lat = (v.op == OP_MUL || v.op == OP_DIV) ? MD : SP;
    if (v.port)
      model_cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, v.op, v.a, v.b);
    else
      model_cycle(1'b1, v.op, v.a, v.b, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < lat + 2; i++) idle_cycle();
    chk("vec_result", result, v.exp);
  endtask

  initial begin
    vecs[0] = '{1'b0, OP_ADD, 32'h5, 32'h3, 64'h0000_0000_0000_0008};
    vecs[1] = '{1'b1, OP_MUL, 32'h0001_0000, 32'h0001_0000,
                64'h0000_0001_0000_0000};
    vecs[2] = '{1'b0, OP_SUB, 32'h3, 32'h5, 64'h0000_0000_FFFF_FFFE};
    vecs[3] = '{1'b1, OP_DIV, 32'd100, 32'd7, 64'h0000_0000_0000_000E};
    vecs[4] = '{1'b0, OP_XOR, 32'hF0F0, 32'h0FF0, 64'h0000_0000_0000_FF00};
    vecs[5] = '{1'b1, 5'b11111, 32'h9, 32'h9, 64'h0};
    vecs[6] = '{1'b0, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001};
    vecs[7] = '{1'b1, OP_AND, 32'hDEAD_BEEF, 32'h0F0F_0F0F,
                64'h0000_0000_0E0D_0E0F};

    g0cnt = 0; g1cnt = 0;
    model_sync();
    reset = 1'b1;
    req0 = 1'b1; op0 = OP_ADD; a0 = 32'd1; b0 = 32'd2;
    req1 = 1'b0; op1 = 5'd0; a1 = 32'd0; b1 = 32'd0;
    reset_hold(2);
    drive(1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, 5'd0, 32'd0, 32'd0);
    model_cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    chk("post_reset_gnt0", 64'(gnt0), 64'h1);
    for (int i = 0; i < 3; i++) idle_cycle();
    chk("post_reset_result", result, 64'h3);

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset in the second EXEC cycle of a divide
    model_cycle(1'b0, 5'd0, 32'd0, 32'd0, 1'b1, OP_DIV, 32'd50, 32'd5);
    idle_cycle();
    idle_cycle();
    reset = 1'b1;
    reset_hold(2);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) idle_cycle();
    chk("abort_result", result, 64'h0);
    run_vec(vecs[0]);

    // both ports held with add and sub
    g0cnt = 0; g1cnt = 0;
    for (int i = 0; i < 12; i++)
      model_cycle(1'b1, OP_ADD, 32'h5, 32'h3, 1'b1, OP_SUB, 32'h3, 32'h5);
    for (int i = 0; i < 4; i++) idle_cycle();
`ifdef ALU_SHARE_RR_EN
    chk("both_g0", 64'(g0cnt), 64'd2);
    chk("both_g1", 64'(g1cnt), 64'd2);
`else
    chk("both_g0", 64'(g0cnt), 64'd4);
    chk("both_g1", 64'(g1cnt), 64'd0);
`endif

    // randomized traffic from a fresh reset
    reset = 1'b1;
    reset_hold(2);
    drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 800; i++) begin
      model_cycle($urandom_range(0, 2) == 0, rand_op(),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 99)),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 99)),
                  $urandom_range(0, 2) == 0, rand_op(),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 99)),
                  ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 99)));
    end
    for (int i = 0; i < MD + 3; i++) idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing and arbitration controller that shares the single combinational 64-bit-result ALU between two requesters, for example the main datapath sequencer and an address-generation path. It latches the winning request's opcode and operands into registers that drive the ALU. It holds them for an opcode-dependent number of cycles so multiply and divide paths settle, then captures the 64-bit result and returns a one-cycle done pulse to the winner. It sits between the requesters and the ALU instance; the ALU itself is unchanged.

## Interface
- MULDIV_CYCLES, 4: hold cycles for opcodes 5'b01111 (mul) and 5'b10000 (div); legal range 1..15.
- SIMPLE_CYCLES, 1: hold cycles for every other opcode; legal range 1..15.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req0 / req1  in  1  level request from port 0 / port 1.
- op0 / op1  in  5  opcode, sampled only on the grant edge.
- a0, b0 / a1, b1  in  32  operands Ra/Rb, sampled only on the grant edge.
- gnt0 / gnt1  out  1  one-cycle pulse; operands were captured on the preceding edge.
- done0 / done1  out  1  one-cycle pulse; result is valid.
- result  out  64  captured ALU result; holds its value until the next capture.
- alu_opcode  out  5  registered drive to ALU opcode.
- alu_ra, alu_rb  out  32  registered drives to ALU Ra and Rb.
- alu_rc  in  64  ALU result.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - EXEC: hold ALU inputs and count down.
  - DONE: pulse done.
- IDLE, at least one reqN high on the edge:
  - Select the winner.
  - Load alu_opcode/alu_ra/alu_rb from the winner.
  - Set gntW=1 for the next cycle.
  - Set cnt = (op is mul/div ? MULDIV_CYCLES : SIMPLE_CYCLES) − 1.
  - Record owner; go to EXEC.
- EXEC:
  - If cnt≠0, decrement cnt.
  - If cnt==0: result ← alu_rc, doneOwner=1, go to DONE.
- DONE: deassert done; go to IDLE. No arbitration occurs in DONE.
- Arbitration: round-robin between the two ports when the macro is defined; see Configuration.
- A requester holding req high after its done is treated as a new request.
- A req dropped before the grant edge is never served. Changes to req or operands after the grant are ignored.
- Opcodes the ALU does not decode use SIMPLE_CYCLES; result is whatever alu_rc presents (0).
- ALU input registers retain their last values in IDLE and DONE.

## Timing
- Reset values: state IDLE, gnt0/1=0, done0/1=0, result=0, alu_opcode=0, alu_ra=0, alu_rb=0, cnt=0. The round-robin pointer gives port 0 priority.
- Reset during EXEC or DONE:
  - Transaction is aborted; no done is emitted.
  - Result returns to 0.
  - Reset dominates all other events in the same cycle.
- Request sampled on edge E0:
  - gnt high during cycle 1.
  - done and new result during cycle L+1, where L is the hold count.
- Simple op: done in cycle 2. Mul/div at the default parameters: done in cycle 5.
- Earliest next grant edge is the end of cycle L+2. Minimum issue interval is L+2 cycles.
- Simultaneous requests in IDLE: exactly one grant, with no combinational path from req to gnt.

## Configuration
- ALU_SHARE_RR_EN defined:
  - Round-robin between the two ports.
  - On simultaneous requests the port not granted most recently wins.
  - Pointer updates on every grant.
- ALU_SHARE_RR_EN undefined:
  - Fixed priority; port 0 always wins on simultaneous requests.
  - No pointer register is implemented.

## Structure
- Shared package/header alu_ops_pkg:
  - 5-bit opcode constants, including MUL=5'b01111 and DIV=5'b10000.
  - FSM state encodings IDLE/EXEC/DONE.
  - Hold-count width (4 bits).
- One sub-module, arb2_rr:
  - Two-input arbiter producing a one-hot winner.
  - Internal pointer under ALU_SHARE_RR_EN.
  - Advances only on an enable asserted on the grant edge.

## Test plan
- Reset: hold reset 2 cycles with req0=1 → all outputs 0, no gnt, state IDLE; release → gnt0 in the following cycle.
- Port 0, op 5'b00011, a0=0x5, b0=0x3 → gnt0 in cycle 1, done0 in cycle 2, result=0x0000_0000_0000_0008, done1 never.
- Port 1, op 5'b01111, a1=0x0001_0000, b1=0x0001_0000, MULDIV_CYCLES=4:
  - alu_ra/alu_rb stable for 4 cycles.
  - done1 in cycle 5, result=0x0000_0001_0000_0000.
- req0 and req1 both held high, ops add and sub:
  - With ALU_SHARE_RR_EN: grants alternate 0, 1, 0, …
  - Without it: port 0 is granted every time.
  - Each port's result matches its own operands, e.g. sub 0x3−0x5 → 0x0000_0000_FFFF_FFFE.
- Reset asserted in the 2nd EXEC cycle of a div → no done pulse, result=0, next request is granted normally.
- Operands changed on a0/b0 the cycle after gnt0 → result reflects the originally sampled operands.
